// File: rtl/row_fifo_serializer_pkg.sv
// Shared types and default geometry for the row-to-word FIFO serializer.
// The row buffer and the rclk-side aggregator use the same constants.
package row_fifo_serializer_pkg;

  localparam int DEF_DATA_WIDTH  = 11;
  localparam int DEF_FETCH_WIDTH = 5;
  localparam int DEF_ADDR_WIDTH  = 7;
  localparam int DEF_DEPTH       = 128;
  localparam int ROW_WIDTH       = DEF_FETCH_WIDTH * DEF_DATA_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // A single-lane row still needs a one-bit counter to stay legal.
  function automatic int lane_cnt_width(input int fetch_width);
    return (fetch_width > 1) ? $clog2(fetch_width) : 1;
  endfunction

endpackage

// File: rtl/row_fifo_serializer.sv
// Reads packed rows from a one-cycle-latency row buffer and pushes them into
// the async FIFO one word per cycle, lane 0 (LSB slice) first, honouring wfull.
module row_fifo_serializer
  import row_fifo_serializer_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FETCH_WIDTH = DEF_FETCH_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic                              wclk,
  input  logic                              wrst_n,
  input  logic                              start,
  input  logic [ADDR_WIDTH-1:0]             start_addr,
  input  logic [ADDR_WIDTH:0]               num_rows,
  output logic                              busy,
  output logic                              done,
  output logic                              mem_ren,
  output logic [ADDR_WIDTH-1:0]             mem_radr,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] mem_rdata,
  output logic                              fifo_winc,
  output logic [DATA_WIDTH-1:0]             fifo_wdata,
  input  logic                              fifo_wfull
);

  localparam int ROW_W  = FETCH_WIDTH * DATA_WIDTH;
  localparam int LANE_W = lane_cnt_width(FETCH_WIDTH);

  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(FETCH_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [ROW_W-1:0]      r_shift;
  logic [LANE_W-1:0]     r_lane;
  logic                  w_write;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge wclk) begin
    if (!wrst_n) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    mem_ren      = 1'b0;
    fifo_winc    = 1'b0;
    w_write      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = (num_rows == '0) ? ST_DONE : ST_READ;
      end
      ST_READ: begin
        busy         = 1'b1;
        mem_ren      = 1'b1;
        w_next_state = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        busy         = 1'b1;
        w_next_state = ST_SEND;
      end
      ST_SEND: begin
        busy      = 1'b1;
        w_write   = !fifo_wfull;
        fifo_winc = w_write;
        if (w_write && (r_lane == LAST_LANE))
          w_next_state = (r_remaining != '0) ? ST_READ : ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: the shift register is a plain datapath register, not a RAM, so it is
  // cleared by reset along with the counters; a dropped row leaves no residue.
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_shift     <= '0;
      r_lane      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr      <= start_addr;
            r_remaining <= num_rows;
          end
        end
        ST_CAPTURE: begin
          r_shift     <= mem_rdata;
          r_lane      <= '0;
          r_addr      <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
          r_remaining <= r_remaining - 1'b1;
        end
        ST_SEND: begin
          // wfull freezes the shift register, so the presented word is retried.
          if (w_write) begin
            r_shift <= r_shift >> DATA_WIDTH;
            r_lane  <= r_lane + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_radr   = r_addr;
  assign fifo_wdata = r_shift[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_row_fifo_serializer.sv
// Directed bench for row_fifo_serializer: row buffer model, FIFO write
// monitor and cycle-accurate checks of the command/handshake timing.
module tb_row_fifo_serializer;
  import row_fifo_serializer_pkg::*;

  localparam int DW    = DEF_DATA_WIDTH;
  localparam int FW    = DEF_FETCH_WIDTH;
  localparam int AW    = DEF_ADDR_WIDTH;
  localparam int DEPTH = DEF_DEPTH;
  localparam int RW    = FW * DW;

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   num_rows;
  logic          busy;
  logic          done;
  logic          mem_ren;
  logic [AW-1:0] mem_radr;
  logic [RW-1:0] mem_rdata = '0;
  logic          fifo_winc;
  logic [DW-1:0] fifo_wdata;
  logic          fifo_wfull;

  logic [RW-1:0] mem [DEPTH];
  logic [DW-1:0] rx_q [$];
  int            done_cnt = 0;

  int n_checks = 0;
  int n_errors = 0;

  row_fifo_serializer #(
    .DATA_WIDTH (DW),
    .FETCH_WIDTH(FW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .start     (start),
    .start_addr(start_addr),
    .num_rows  (num_rows),
    .busy      (busy),
    .done      (done),
    .mem_ren   (mem_ren),
    .mem_radr  (mem_radr),
    .mem_rdata (mem_rdata),
    .fifo_winc (fifo_winc),
    .fifo_wdata(fifo_wdata),
    .fifo_wfull(fifo_wfull)
  );

  always #5 wclk = ~wclk;

  // Row buffer with one-cycle read latency.
  always @(posedge wclk) if (mem_ren) mem_rdata <= mem[mem_radr];

  // FIFO write-port monitor.
  always @(posedge wclk) begin
    if (fifo_winc) rx_q.push_back(fifo_wdata);
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] make_row(input int base);
    logic [RW-1:0] row = '0;
    for (int i = 0; i < FW; i++) row[i*DW +: DW] = DW'(base + i);
    return row;
  endfunction

  function automatic logic [63:0] rx_word(input int idx);
    if (idx < rx_q.size()) return 64'(rx_q[idx]);
    return 'x;
  endfunction

  task automatic issue(input int addr, input int n);
    start      = 1'b1;
    start_addr = AW'(addr);
    num_rows   = (AW+1)'(n);
  endtask

  // Returns the number of cycles waited before done was seen, or -1.
  task automatic wait_done(input int budget, output int cycles);
    cycles = -1;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        cycles = i;
        return;
      end
      step();
    end
  endtask

  initial begin
    int base;
    int dbase;
    int cyc;
    logic [RW-1:0] row;

    for (int r = 0; r < DEPTH; r++) mem[r] = '0;
    wrst_n = 1'b0; start = 1'b0; start_addr = '0; num_rows = '0; fifo_wfull = 1'b0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ren", mem_ren, 0);
    check("rst_winc", fifo_winc, 0);
    check("rst_radr", mem_radr, 0);
    check("rst_wdata", fifo_wdata, 0);
    wrst_n = 1'b1;
    step();

    // Single row, no backpressure.
    mem[0] = make_row(1);
    base = rx_q.size();
    issue(0, 1);
    step(); start = 1'b0;
    check("t1_c1_ren", mem_ren, 1);
    check("t1_c1_radr", mem_radr, 0);
    check("t1_c1_busy", busy, 1);
    step();
    check("t1_c2_ren", mem_ren, 0);
    check("t1_c2_winc", fifo_winc, 0);
    for (int k = 0; k < FW; k++) begin
      step();
      check($sformatf("t1_c%0d_winc", k + 3), fifo_winc, 1);
      check($sformatf("t1_c%0d_wdata", k + 3), fifo_wdata, k + 1);
    end
    step();
    check("t1_c8_done", done, 1);
    check("t1_c8_busy", busy, 0);
    check("t1_c8_winc", fifo_winc, 0);
    step();
    check("t1_c9_done", done, 0);
    check("t1_words", rx_q.size() - base, 5);

    // Backpressure in cycles 4-5.
    base = rx_q.size();
    issue(0, 1);
    step(); start = 1'b0;
    step();
    step();
    check("t2_c3_wdata", fifo_wdata, 1);
    step(); fifo_wfull = 1'b1; #1;
    check("t2_c4_winc", fifo_winc, 0);
    check("t2_c4_wdata", fifo_wdata, 2);
    step();
    check("t2_c5_winc", fifo_winc, 0);
    check("t2_c5_wdata", fifo_wdata, 2);
    step(); fifo_wfull = 1'b0; #1;
    check("t2_c6_winc", fifo_winc, 1);
    check("t2_c6_wdata", fifo_wdata, 2);
    for (int k = 3; k <= 5; k++) begin
      step();
      check($sformatf("t2_c%0d_wdata", k + 4), fifo_wdata, k);
    end
    step();
    check("t2_c10_done", done, 1);
    for (int k = 0; k < FW; k++) check($sformatf("t2_word%0d", k), rx_word(base + k), k + 1);
    check("t2_words", rx_q.size() - base, 5);

    // Address wrap 127 -> 0.
    mem[127] = make_row(10);
    step();
    base = rx_q.size(); dbase = done_cnt;
    issue(127, 2);
    step(); start = 1'b0;
    check("t3_c1_radr", mem_radr, 127);
    repeat (7) step();
    check("t3_c8_ren", mem_ren, 1);
    check("t3_c8_radr", mem_radr, 0);
    wait_done(30, cyc);
    check("t3_done_latency", cyc, 7);
    step();
    check("t3_words", rx_q.size() - base, 10);
    for (int k = 0; k < FW; k++) check($sformatf("t3_w%0d", k), rx_word(base + k), 10 + k);
    for (int k = 0; k < FW; k++) check($sformatf("t3_w%0d", k + 5), rx_word(base + 5 + k), 1 + k);
    check("t3_done_once", done_cnt - dbase, 1);

    // Zero rows.
    base = rx_q.size();
    issue(0, 0);
    step(); start = 1'b0;
    check("t4_c1_done", done, 1);
    check("t4_c1_ren", mem_ren, 0);
    check("t4_c1_winc", fifo_winc, 0);
    check("t4_c1_busy", busy, 0);
    step();
    check("t4_c2_done", done, 0);
    check("t4_words", rx_q.size() - base, 0);

    // Start while busy is ignored.
    base = rx_q.size();
    issue(0, 1);
    step(); start = 1'b0;
    repeat (3) step();
    issue(127, 3);
    step(); start = 1'b0;
    wait_done(20, cyc);
    check("t5_done_latency", cyc, 3);
    repeat (4) step();
    check("t5_busy_after", busy, 0);
    check("t5_words", rx_q.size() - base, 5);

    // Reset at lane 2, then a clean one-row command from address 5.
    issue(0, 1);
    step(); start = 1'b0;
    repeat (4) step();
    check("t6_lane2_wdata", fifo_wdata, 3);
    wrst_n = 1'b0;
    step();
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_ren", mem_ren, 0);
    check("t6_winc", fifo_winc, 0);
    check("t6_radr", mem_radr, 0);
    check("t6_wdata", fifo_wdata, 0);
    check("t6_state", dut.r_state, ST_IDLE);
    wrst_n = 1'b1;
    step();
    mem[5] = make_row(50);
    base = rx_q.size();
    issue(5, 1);
    step(); start = 1'b0;
    check("t6_radr5", mem_radr, 5);
    wait_done(20, cyc);
    check("t6_done_latency", cyc, 7);
    step();
    check("t6_words", rx_q.size() - base, 5);
    for (int k = 0; k < FW; k++) check($sformatf("t6_w%0d", k), rx_word(base + k), 50 + k);

    // All rows of ramp data with random stalls.
    for (int r = 0; r < DEPTH; r++) mem[r] = make_row(r * FW);
    base = rx_q.size();
    issue(0, DEPTH);
    step(); start = 1'b0;
    cyc = -1;
    for (int i = 0; i < 6000; i++) begin
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
      fifo_wfull = ($urandom_range(0, 3) == 0);
      step();
    end
    fifo_wfull = 1'b0;
    check("t7_done_seen", (cyc >= 0), 1);
    step();
    check("t7_words", rx_q.size() - base, DEPTH * FW);
    if (rx_q.size() - base == DEPTH * FW) begin
      for (int r = 0; r < DEPTH; r++) begin
        row = '0;
        for (int i = 0; i < FW; i++) row[i*DW +: DW] = rx_q[base + r*FW + i];
        check($sformatf("t7_row%0d", r), 64'(row), 64'(make_row(r * FW)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
